// File: rtl/stack_seq_cu.sv
// Stack-sequencing control unit: pushes/pops the PC (as NPC memory words) and flags
// for CALL, RET, RTI and interrupt entry, one memory beat per mem_ready.
module stack_seq_cu #(
    parameter int PCW   = 32,
    parameter int WORDW = 16,
    parameter int FLAGW = 4,
    localparam int NPC  = PCW / WORDW,
    localparam int SELW = (NPC > 1) ? $clog2(NPC) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [7:0]      Opcode,
    input  logic            INT,
    input  logic            mem_ready,
    output logic            op_accept,
    output logic            stall,
    output logic            MW,
    output logic            MR,
    output logic [SELW-1:0] pc_word_sel,
    output logic            flag_beat,
    output logic            pc_load,
    output logic [1:0]      pc_src,
    output logic            int_ack,
    output logic            int_en
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_PC, S_PUSH_FLG, S_POP_FLG, S_POP_PC, S_LOAD_PC
    } state_t;

    typedef enum logic [1:0] {K_CALL, K_INT, K_RET, K_RTI} kind_t;

    localparam logic [SELW-1:0] LAST_IDX = SELW'(NPC - 1);

    state_t          r_state;
    kind_t           r_kind;
    logic [SELW-1:0] r_idx;
    logic            r_int_pend;
    logic            r_int_en;

    logic w_is_call, w_is_ret, w_is_rti, w_pend, w_idle, w_take_int;
    logic w_unused;

    assign w_is_call  = (Opcode[7:3] == 5'b10110);
    assign w_is_ret   = (Opcode[7:3] == 5'b11110) && !Opcode[0];
    assign w_is_rti   = (Opcode[7:3] == 5'b11110) && Opcode[0];
    // A request arriving this very cycle is serviced as if it were already pending.
    assign w_pend     = r_int_pend | INT;
    assign w_idle     = (r_state == S_IDLE);
    assign w_take_int = w_idle && w_pend && r_int_en && !rst;
    assign w_unused   = &{1'b0, Opcode[2:1], (FLAGW <= WORDW)};

    assign op_accept   = w_idle && op_valid && !w_take_int && !rst;
    assign stall       = !rst && (!w_idle || w_take_int);
    assign MW          = (r_state == S_PUSH_PC) || (r_state == S_PUSH_FLG);
    assign MR          = (r_state == S_POP_PC)  || (r_state == S_POP_FLG);
    assign flag_beat   = (r_state == S_PUSH_FLG) || (r_state == S_POP_FLG);
    assign pc_word_sel = r_idx;
    assign pc_load     = (r_state == S_LOAD_PC);
    assign int_ack     = pc_load && (r_kind == K_INT);
    assign pc_src      = !pc_load           ? 2'b00 :
                         (r_kind == K_INT)  ? 2'b01 :
                         (r_kind == K_CALL) ? 2'b10 : 2'b00;
    assign int_en      = r_int_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_kind     <= K_CALL;
            r_idx      <= '0;
            r_int_pend <= 1'b0;
            r_int_en   <= 1'b1;
        end else begin
            r_int_pend <= r_int_pend | INT;
            case (r_state)
                S_IDLE: begin
                    if (w_take_int) begin
                        r_state    <= S_PUSH_PC;
                        r_kind     <= K_INT;
                        r_idx      <= '0;
                        r_int_pend <= 1'b0;
                        r_int_en   <= 1'b0;
                    end else if (op_valid) begin
                        if (w_is_call) begin
                            r_state <= S_PUSH_PC;
                            r_kind  <= K_CALL;
                            r_idx   <= '0;
                        end else if (w_is_ret) begin
                            r_state <= S_POP_PC;
                            r_kind  <= K_RET;
                            r_idx   <= LAST_IDX;
                        end else if (w_is_rti) begin
                            r_state <= S_POP_FLG;
                            r_kind  <= K_RTI;
                            r_idx   <= '0;
                        end
                    end
                end
                S_PUSH_PC: begin
                    if (mem_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= (r_kind == K_INT) ? S_PUSH_FLG : S_LOAD_PC;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_PUSH_FLG: begin
                    if (mem_ready) r_state <= S_LOAD_PC;
                end
                S_POP_FLG: begin
                    if (mem_ready) begin
                        r_state <= S_POP_PC;
                        r_idx   <= LAST_IDX;
                    end
                end
                S_POP_PC: begin
                    if (mem_ready) begin
                        if (r_idx == '0) r_state <= S_LOAD_PC;
                        else             r_idx   <= r_idx - 1'b1;
                    end
                end
                S_LOAD_PC: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    if (r_kind == K_RTI) r_int_en <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_seq_cu.sv
// Directed bench for stack_seq_cu (PCW=32, WORDW=16): per-cycle output vectors
// {op_accept,stall,MW,MR,sel,flag_beat,pc_load,pc_src,int_ack,int_en}.
module tb_stack_seq_cu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [7:0] Opcode = 8'h00;
    logic       INT = 1'b0;
    logic       mem_ready = 1'b0;
    logic       op_accept, stall, MW, MR, pc_word_sel, flag_beat, pc_load, int_ack, int_en;
    logic [1:0] pc_src;

    int checks = 0;
    int errors = 0;

    stack_seq_cu dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .Opcode(Opcode), .INT(INT),
        .mem_ready(mem_ready), .op_accept(op_accept), .stall(stall), .MW(MW), .MR(MR),
        .pc_word_sel(pc_word_sel), .flag_beat(flag_beat), .pc_load(pc_load),
        .pc_src(pc_src), .int_ack(int_ack), .int_en(int_en)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] stim(input logic r, input logic v, input logic [7:0] op,
                                         input logic irq, input logic mr);
        return {r, v, op, irq, mr};
    endfunction

    task automatic apply(input logic [11:0] s);
        {rst, op_valid, Opcode, INT, mem_ready} = s;
        #1;
    endtask

    function automatic logic [10:0] observe();
        return {op_accept, stall, MW, MR, pc_word_sel, flag_beat, pc_load, pc_src, int_ack, int_en};
    endfunction

    task automatic test_reset();
        logic [10:0] obs;
        apply(stim(1, 0, 8'h00, 0, 0));
        @(negedge clk);
        apply(stim(1, 1, 8'hB0, 1, 1));
        obs = observe();
        checks++;
        if (obs !== 11'b0_0_0_0_0_0_0_00_0_1) begin
            errors++;
            $display("FAIL reset_hold got %b want %b", obs, 11'b0_0_0_0_0_0_0_00_0_1);
        end
        @(negedge clk);
        apply(stim(0, 1, 8'h00, 0, 1));
        obs = observe();
        checks++;
        if (obs !== 11'b1_0_0_0_0_0_0_00_0_1) begin
            errors++;
            $display("FAIL reset_release got %b want %b", obs, 11'b1_0_0_0_0_0_0_00_0_1);
        end
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_call();
        logic [11:0] st [5];
        logic [10:0] ex [5];
        logic [10:0] obs;
        st = '{stim(0,1,8'hB0,0,1), stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1),
               stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1)};
        ex = '{11'b1_0_0_0_0_0_0_00_0_1, 11'b0_1_1_0_0_0_0_00_0_1, 11'b0_1_1_0_1_0_0_00_0_1,
               11'b0_1_0_0_0_0_1_10_0_1, 11'b0_0_0_0_0_0_0_00_0_1};
        for (int i = 0; i < 5; i++) begin
            apply(st[i]);
            obs = observe();
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL call cyc%0d got %b want %b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
        $display("test_call done");
    endtask

    task automatic test_int();
        logic [11:0] st [6];
        logic [10:0] ex [6];
        logic [10:0] obs;
        st = '{stim(0,1,8'h00,1,1), stim(0,1,8'h00,0,1), stim(0,1,8'h00,0,1),
               stim(0,1,8'h00,0,1), stim(0,1,8'h00,0,1), stim(0,1,8'h00,0,1)};
        ex = '{11'b0_1_0_0_0_0_0_00_0_1, 11'b0_1_1_0_0_0_0_00_0_0, 11'b0_1_1_0_1_0_0_00_0_0,
               11'b0_1_1_0_0_1_0_00_0_0, 11'b0_1_0_0_0_0_1_01_1_0, 11'b1_0_0_0_0_0_0_00_0_0};
        for (int i = 0; i < 6; i++) begin
            apply(st[i]);
            obs = observe();
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL int_entry cyc%0d got %b want %b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
        $display("test_int done");
    endtask

    task automatic test_rti_stall();
        logic [11:0] st [8];
        logic [10:0] ex [8];
        logic [10:0] obs;
        st = '{stim(0,1,8'hF1,0,0), stim(0,0,8'h00,0,0), stim(0,0,8'h00,0,0),
               stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1),
               stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1)};
        ex = '{11'b1_0_0_0_0_0_0_00_0_0, 11'b0_1_0_1_0_1_0_00_0_0, 11'b0_1_0_1_0_1_0_00_0_0,
               11'b0_1_0_1_0_1_0_00_0_0, 11'b0_1_0_1_1_0_0_00_0_0, 11'b0_1_0_1_0_0_0_00_0_0,
               11'b0_1_0_0_0_0_1_00_0_0, 11'b0_0_0_0_0_0_0_00_0_1};
        for (int i = 0; i < 8; i++) begin
            apply(st[i]);
            obs = observe();
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL rti_stall cyc%0d got %b want %b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
        $display("test_rti_stall done");
    endtask

    task automatic test_int_during_ret();
        logic [11:0] st [10];
        logic [10:0] ex [10];
        logic [10:0] obs;
        st = '{stim(0,1,8'hF0,0,1), stim(0,0,8'h00,1,1), stim(0,0,8'h00,0,1),
               stim(0,0,8'h00,0,1), stim(0,1,8'h00,0,1), stim(0,0,8'h00,0,1),
               stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1),
               stim(0,0,8'h00,0,1)};
        ex = '{11'b1_0_0_0_0_0_0_00_0_1, 11'b0_1_0_1_1_0_0_00_0_1, 11'b0_1_0_1_0_0_0_00_0_1,
               11'b0_1_0_0_0_0_1_00_0_1, 11'b0_1_0_0_0_0_0_00_0_1, 11'b0_1_1_0_0_0_0_00_0_0,
               11'b0_1_1_0_1_0_0_00_0_0, 11'b0_1_1_0_0_1_0_00_0_0, 11'b0_1_0_0_0_0_1_01_1_0,
               11'b0_0_0_0_0_0_0_00_0_0};
        for (int i = 0; i < 10; i++) begin
            apply(st[i]);
            obs = observe();
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL int_during_ret cyc%0d got %b want %b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
        $display("test_int_during_ret done");
    endtask

    task automatic test_int_masked();
        logic [11:0] st [12];
        logic [10:0] ex [12];
        logic [10:0] obs;
        st = '{stim(0,0,8'h00,1,1), stim(0,1,8'hF1,0,1), stim(0,0,8'h00,0,1),
               stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1),
               stim(0,1,8'h00,0,1), stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1),
               stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1)};
        ex = '{11'b0_0_0_0_0_0_0_00_0_0, 11'b1_0_0_0_0_0_0_00_0_0, 11'b0_1_0_1_0_1_0_00_0_0,
               11'b0_1_0_1_1_0_0_00_0_0, 11'b0_1_0_1_0_0_0_00_0_0, 11'b0_1_0_0_0_0_1_00_0_0,
               11'b0_1_0_0_0_0_0_00_0_1, 11'b0_1_1_0_0_0_0_00_0_0, 11'b0_1_1_0_1_0_0_00_0_0,
               11'b0_1_1_0_0_1_0_00_0_0, 11'b0_1_0_0_0_0_1_01_1_0, 11'b0_0_0_0_0_0_0_00_0_0};
        for (int i = 0; i < 12; i++) begin
            apply(st[i]);
            obs = observe();
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL int_masked cyc%0d got %b want %b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
        $display("test_int_masked done");
    endtask

    task automatic test_reset_mid();
        logic [10:0] obs;
        apply(stim(0, 1, 8'hB0, 0, 1));
        obs = observe();
        checks++;
        if (obs !== 11'b1_0_0_0_0_0_0_00_0_0) begin
            errors++;
            $display("FAIL reset_mid_call got %b want %b", obs, 11'b1_0_0_0_0_0_0_00_0_0);
        end
        @(negedge clk);
        apply(stim(0, 0, 8'h00, 0, 1));
        obs = observe();
        checks++;
        if (obs !== 11'b0_1_1_0_0_0_0_00_0_0) begin
            errors++;
            $display("FAIL reset_mid_push0 got %b want %b", obs, 11'b0_1_1_0_0_0_0_00_0_0);
        end
        @(negedge clk);
        apply(stim(1, 1, 8'hB0, 1, 1));
        @(negedge clk);
        apply(stim(0, 1, 8'h00, 0, 1));
        obs = observe();
        checks++;
        if (obs !== 11'b1_0_0_0_0_0_0_00_0_1) begin
            errors++;
            $display("FAIL reset_mid_after got %b want %b", obs, 11'b1_0_0_0_0_0_0_00_0_1);
        end
        @(negedge clk);
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        logic [11:0] st [8];
        logic [10:0] ex [8];
        logic [10:0] obs;
        st = '{stim(0,1,8'hB8,0,1), stim(0,1,8'hF8,0,1), stim(0,1,8'hB7,0,1),
               stim(0,0,8'h00,0,0), stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1),
               stim(0,0,8'h00,0,1), stim(0,0,8'h00,0,1)};
        ex = '{11'b1_0_0_0_0_0_0_00_0_1, 11'b1_0_0_0_0_0_0_00_0_1, 11'b1_0_0_0_0_0_0_00_0_1,
               11'b0_1_1_0_0_0_0_00_0_1, 11'b0_1_1_0_0_0_0_00_0_1, 11'b0_1_1_0_1_0_0_00_0_1,
               11'b0_1_0_0_0_0_1_10_0_1, 11'b0_0_0_0_0_0_0_00_0_1};
        for (int i = 0; i < 8; i++) begin
            apply(st[i]);
            obs = observe();
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got %b want %b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_call();
        test_int();
        test_rti_stall();
        test_int_during_ret();
        test_int_masked();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_seq_cu.md
STACK_SEQ_CU -- requirements
Module: stack_seq_cu

Interface
REQ-001 SHALL have parameter PCW, default 32: program-counter width in bits.
REQ-002 SHALL have parameter WORDW, default 16: data-memory word width; PCW SHALL be a multiple of WORDW, NPC = PCW/WORDW >= 2.
REQ-003 SHALL have parameter FLAGW, default 4: flag-register width (at most WORDW).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port op_valid  in  1  decode stage presents an instruction.
REQ-007 SHALL have port Opcode  in  8  instruction opcode.
REQ-008 SHALL have port INT  in  1  interrupt request, level or pulse.
REQ-009 SHALL have port mem_ready  in  1  memory stage completes the current stack beat this cycle.
REQ-010 SHALL have port op_accept  out  1  instruction consumed this cycle.
REQ-011 SHALL have port stall  out  1  freeze fetch/decode.
REQ-012 SHALL have port MW  out  1  stack write beat.
REQ-013 SHALL have port MR  out  1  stack read beat.
REQ-014 SHALL have port pc_word_sel  out  clog2(NPC)  PC word index of the current beat.
REQ-015 SHALL have port flag_beat  out  1  current beat carries flags (low FLAGW bits), not a PC word.
REQ-016 SHALL have port pc_load  out  1  load PC this cycle.
REQ-017 SHALL have port pc_src  out  2  00 popped words, 01 interrupt vector, 10 call target.
REQ-018 SHALL have port int_ack  out  1  one-cycle interrupt-entry acknowledge.
REQ-019 SHALL have port int_en  out  1  interrupts enabled.

Function
REQ-020 SHALL decode: CALL = Opcode[7:3]==10110; RET = Opcode[7:3]==11110 && !Opcode[0]; RTI = Opcode[7:3]==11110 && Opcode[0]; all other opcodes are plain.
REQ-021 SHALL implement states IDLE, PUSH_PC, PUSH_FLG, POP_FLG, POP_PC, LOAD_PC; outputs SHALL be decoded from state registers only (Moore), except op_accept.
REQ-022 SHALL latch INT into int_pend every cycle it is high; int_pend is a single bit and extra requests while it is set are absorbed.
REQ-023 SHALL, in IDLE with int_pend && int_en: clear op_accept, enter PUSH_PC with idx=0, clear int_pend, clear int_en.
REQ-024 SHALL, in IDLE otherwise: op_accept = op_valid; CALL -> PUSH_PC idx=0; RET -> POP_PC idx=NPC-1; RTI -> POP_FLG; plain -> stay IDLE, no stall.
REQ-025 SHALL assert MW in PUSH_PC/PUSH_FLG and MR in POP_PC/POP_FLG; pc_word_sel = idx; flag_beat = 1 only in PUSH_FLG/POP_FLG.
REQ-026 SHALL advance a beat only when mem_ready=1; with mem_ready=0 the state, idx and outputs SHALL hold unchanged indefinitely.
REQ-027 SHALL push PC words ascending idx 0..NPC-1; pop PC words descending NPC-1..0.
REQ-028 SHALL, after last PUSH_PC beat: INT sequence -> PUSH_FLG; CALL -> LOAD_PC.
REQ-029 SHALL, after PUSH_FLG beat -> LOAD_PC; after POP_FLG beat -> POP_PC idx=NPC-1; after last POP_PC beat -> LOAD_PC.
REQ-030 SHALL, in LOAD_PC (exactly one cycle): pc_load=1; pc_src 01 for INT, 10 for CALL, 00 for RET/RTI; int_ack=1 only for INT; set int_en for RTI; next state IDLE.
REQ-031 SHALL assert stall in every non-IDLE state and in IDLE when op_accept=0 due to interrupt entry.
REQ-032 SHALL latch INT arriving mid-sequence and service it on the first IDLE cycle after LOAD_PC, before any new instruction.
REQ-033 SHALL give INT priority over a simultaneous op_valid; the instruction SHALL remain un-accepted and be re-presented.
REQ-034 SHALL latency: CALL = NPC beats + 1 cycle; INT = NPC+1 beats + 1; RET = NPC beats + 1; RTI = NPC+1 beats + 1 (beats at mem_ready=1).

Reset
REQ-035 SHALL on rst=1 at a clock edge force IDLE, idx=0, int_pend=0, int_en=1; all outputs 0 except int_en=1; mid-sequence operations SHALL abort with no further MR/MW/pc_load.
REQ-036 SHALL ignore INT and op_valid in the cycle rst is high.

Verification (PCW=32, WORDW=16, NPC=2)
REQ-037 CALL (Opcode=0xB0), mem_ready=1 -> MW idx0, MW idx1, pc_load pc_src=10, then IDLE; stall high 3 cycles.
REQ-038 INT pulse in IDLE with op_valid=1 -> op_accept=0; MW idx0, idx1, MW flag_beat, pc_load pc_src=01 with int_ack=1; int_en=0 afterward.
REQ-039 RTI (Opcode=0xF1) with mem_ready low 2 cycles on first beat -> MR flag_beat held 3 cycles, MR idx1, MR idx0, pc_load pc_src=00; int_en=1.
REQ-040 INT during a RET's first POP_PC beat -> RET completes normally, then INT sequence starts on next IDLE cycle.
REQ-041 INT while int_en=0 -> pending held; serviced immediately after RTI LOAD_PC.
REQ-042 rst asserted during PUSH_PC idx1 -> next cycle IDLE, MW=0, pc_load=0, int_en=1, int_pend=0.
